enemy_spawner: RTL
==================

// Module: enemy_spawner
// PURPOSE
//  Consumer of the rand LFSR stream. Every N frames, captures one random word and reduces it to an
//  on-screen X coordinate plus an enemy type. Offers the result to the enemy pool with a valid/ready
//  handshake. Sits between rand and the enemy manager in the game-logic layer, clocked by clk_vga.
// PARAMETERS
//  RAND_W        16   width of rand_i; must equal `RAND_WIDTH
//  X_W           10   width of spawn_x
//  X_RANGE       400  spawn_x is uniform-ish in 0..X_RANGE-1; must satisfy 0 < X_RANGE <= 2**X_W
//  INTERVAL_INIT 60   frames between spawns after reset/restart (1..255)
//  INTERVAL_MIN  15   lower bound of interval (difficulty feature only)
//  DIFF_STEP     8    accepted spawns per interval decrement (difficulty feature only)
// PORTS
//  clk_vga      in   1       pixel clock, single clock domain
//  rst_n        in   1       asynchronous, active-low reset
//  game_run     in   1       level: 1 = spawning enabled, 0 = abort and hold in IDLE
//  frame_tick   in   1       one-cycle pulse per frame (start of vblank)
//  rand_i       in   RAND_W  free-running rand output, sampled only in CAPTURE
//  spawn_ready  in   1       enemy pool can accept a spawn
//  spawn_valid  out  1       spawn_x/spawn_type valid; held until accepted
//  spawn_x      out  X_W     X coordinate, < X_RANGE whenever spawn_valid=1
//  spawn_type   out  2       enemy type = rand_i[RAND_W-1:RAND_W-2] at capture
//  spawn_cnt    out  8       accepted spawns since restart, saturates at 255
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, spawn_valid=0, spawn_x=0, spawn_type=0, spawn_cnt=0,
//    frame counter=0, interval=INTERVAL_INIT. All outputs registered.
//  - States: IDLE -> WAIT -> CAPTURE -> REDUCE -> OFFER -> WAIT.
//  - IDLE: when game_run=1, next cycle WAIT with frame counter=0, interval=INTERVAL_INIT, spawn_cnt=0.
//  - WAIT: counter +1 on each frame_tick; on the tick making counter==interval, clear counter, go CAPTURE.
//    frame_tick outside WAIT is ignored (interval measured from end of previous handshake).
//  - CAPTURE (1 cycle): acc <= rand_i[X_W+1:0] (X_W+2 bits), spawn_type <= rand_i[RAND_W-1:RAND_W-2].
//  - REDUCE: per cycle, if acc >= X_RANGE then acc <= acc - X_RANGE, else spawn_x <= acc, spawn_valid <= 1,
//    go OFFER. Subtraction in X_W+2 bits, no wrap. Worst case ceil(2**(X_W+2)/X_RANGE) cycles (11 @ default).
//  - OFFER: spawn_valid, spawn_x, spawn_type stable until spawn_valid&spawn_ready at a clk edge;
//    then spawn_valid <= 0, spawn_cnt +1 (sat 255), go WAIT. spawn_ready while spawn_valid=0 ignored.
//  - game_run=0 in any non-IDLE state: next cycle IDLE, spawn_valid <= 0, counter cleared.
//    If spawn_valid&spawn_ready in that same cycle, the transfer counts (spawn_cnt +1) before IDLE.
//    spawn_x/spawn_type retain last values in IDLE.
//  - End-to-end latency frame_tick(expiry) -> spawn_valid: 2 + k cycles, k = subtractions performed.
// CONFIGURATION
//  ENEMY_SPAWN_DIFFICULTY_EN:
//   defined:   after every DIFF_STEP accepted spawns (spawn_cnt mod DIFF_STEP == 0 after increment),
//              interval <= max(interval-1, INTERVAL_MIN); applied on the accepting edge, used by next WAIT.
//              Restart via IDLE restores INTERVAL_INIT.
//   undefined: interval constant INTERVAL_INIT; no difficulty logic synthesised; INTERVAL_MIN, DIFF_STEP unused.
// TESTING
//  1 Reset: rst_n=0 mid-OFFER -> all outputs 0 immediately (async), IDLE after release.
//  2 game_run=1, INTERVAL_INIT=60, spawn_ready=1, rand_i=16'h0123 -> spawn_valid after 60th tick,
//    spawn_x=291 (0x123 <400, k=0), spawn_type=0, one-cycle valid, spawn_cnt=1.
//  3 rand_i=16'hCFFF -> acc=0xFFF=4095, 10 subtractions -> spawn_x=95, spawn_type=3, valid 12 cycles after tick.
//  4 spawn_ready=0 for 500 cycles during OFFER -> spawn_valid/x/type stable, frame_ticks ignored;
//    ready=1 -> one transfer, next spawn exactly 60 ticks later.
//  5 game_run 1->0 in REDUCE -> spawn_valid stays 0, IDLE; game_run=1 again -> spawn_cnt=0, full 60-tick wait.
//  6 ENEMY_SPAWN_DIFFICULTY_EN, DIFF_STEP=8: after 8 accepts interval=59; after 360 accepts interval=15, stays 15.

Source files
------------

// File: rtl/enemy_spawner.sv
// -----------------------------------------------------------------------------
// enemy_spawner
//   Takes one word from the free-running rand stream every `interval` frames,
//   turns it into an on-screen X coordinate (0..X_RANGE-1) plus a 2-bit
//   enemy type, and offers the result to the enemy pool over valid/ready.
//   Sequence: IDLE -> WAIT -> CAPTURE -> REDUCE -> OFFER -> WAIT.
//
// Ports
//   clk_vga      in   pixel clock (single domain)
//   rst_n        in   asynchronous active-low reset
//   game_run     in   level; 0 aborts to IDLE from any state
//   frame_tick   in   one-cycle pulse per frame, counted only in WAIT
//   rand_i       in   RAND_W-bit random word, sampled in CAPTURE
//   spawn_ready  in   enemy pool can take a spawn
//   spawn_valid  out  spawn_x/spawn_type valid, held until accepted
//   spawn_x      out  X coordinate, < X_RANGE while spawn_valid=1
//   spawn_type   out  enemy type (top two bits of rand_i at capture)
//   spawn_cnt    out  accepted spawns since restart, saturating at 255
//
// Build option
//   ENEMY_SPAWN_DIFFICULTY_EN : every DIFF_STEP accepted spawns the frame
//   interval shrinks by one, down to INTERVAL_MIN. Undefined: fixed interval.
//   RAND_W is expected to match `RAND_WIDTH of the rand block.
// -----------------------------------------------------------------------------
module enemy_spawner #(
   parameter int RAND_W        = 16,
   parameter int X_W           = 10,
   parameter int X_RANGE       = 400,
   parameter int INTERVAL_INIT = 60,
   parameter int INTERVAL_MIN  = 15,
   parameter int DIFF_STEP     = 8
) (
   input  logic              clk_vga,
   input  logic              rst_n,
   input  logic              game_run,
   input  logic              frame_tick,
   input  logic [RAND_W-1:0] rand_i,
   input  logic              spawn_ready,
   output logic              spawn_valid,
   output logic [X_W-1:0]    spawn_x,
   output logic [1:0]        spawn_type,
   output logic [7:0]        spawn_cnt
);

   localparam int               ACC_W    = X_W + 2;
   localparam logic [ACC_W-1:0] RANGE    = ACC_W'(X_RANGE);
   localparam logic [7:0]       INT_INIT = 8'(INTERVAL_INIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_CAPTURE,
      S_REDUCE,
      S_OFFER
   } state_t;

   state_t           state, state_n;
   logic [7:0]       frame_cnt, frame_cnt_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic             valid_n;
   logic [X_W-1:0]   x_n;
   logic [1:0]       type_n;
   logic [7:0]       cnt_n;
   logic             accept;
   logic [7:0]       interval;

`ifdef ENEMY_SPAWN_DIFFICULTY_EN
   logic [7:0] interval_n;
   // Counts accepts modulo DIFF_STEP; spawn_cnt saturates so it cannot be used.
   logic [7:0] step_cnt, step_cnt_n;
   logic       unused_sink;
   assign unused_sink = ^rand_i;
`else
   logic       unused_sink;
   assign interval    = INT_INIT;
   assign unused_sink = ^{rand_i, 8'(INTERVAL_MIN), 8'(DIFF_STEP)};
`endif

   // valid is only ever high in OFFER, so this is the handshake transfer
   assign accept = spawn_valid & spawn_ready;

   always_comb begin
      state_n     = state;
      frame_cnt_n = frame_cnt;
      acc_n       = acc;
      valid_n     = spawn_valid;
      x_n         = spawn_x;
      type_n      = spawn_type;
      cnt_n       = spawn_cnt;
`ifdef ENEMY_SPAWN_DIFFICULTY_EN
      interval_n  = interval;
      step_cnt_n  = step_cnt;
`endif

      // A transfer counts even on the cycle game_run drops.
      if (accept) begin
         if (spawn_cnt != 8'hFF) cnt_n = spawn_cnt + 8'd1;
`ifdef ENEMY_SPAWN_DIFFICULTY_EN
         if (step_cnt == 8'(DIFF_STEP - 1)) begin
            step_cnt_n = '0;
            interval_n = (interval > 8'(INTERVAL_MIN)) ? interval - 8'd1 : 8'(INTERVAL_MIN);
         end else begin
            step_cnt_n = step_cnt + 8'd1;
         end
`endif
      end

      if (state != S_IDLE && !game_run) begin
         state_n     = S_IDLE;
         valid_n     = 1'b0;
         frame_cnt_n = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (game_run) begin
                  state_n     = S_WAIT;
                  frame_cnt_n = '0;
                  cnt_n       = '0;
`ifdef ENEMY_SPAWN_DIFFICULTY_EN
                  interval_n  = INT_INIT;
                  step_cnt_n  = '0;
`endif
               end
            end
            S_WAIT: begin
               if (frame_tick) begin
                  if (frame_cnt + 8'd1 == interval) begin
                     frame_cnt_n = '0;
                     state_n     = S_CAPTURE;
                  end else begin
                     frame_cnt_n = frame_cnt + 8'd1;
                  end
               end
            end
            S_CAPTURE: begin
               acc_n   = rand_i[ACC_W-1:0];
               type_n  = rand_i[RAND_W-1:RAND_W-2];
               state_n = S_REDUCE;
            end
            S_REDUCE: begin
               // Repeated subtraction: modulo without a divider.
               if (acc >= RANGE) begin
                  acc_n = acc - RANGE;
               end else begin
                  x_n     = acc[X_W-1:0];
                  valid_n = 1'b1;
                  state_n = S_OFFER;
               end
            end
            S_OFFER: begin
               if (accept) begin
                  valid_n = 1'b0;
                  state_n = S_WAIT;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         frame_cnt   <= '0;
         acc         <= '0;
         spawn_valid <= 1'b0;
         spawn_x     <= '0;
         spawn_type  <= '0;
         spawn_cnt   <= '0;
`ifdef ENEMY_SPAWN_DIFFICULTY_EN
         interval    <= INT_INIT;
         step_cnt    <= '0;
`endif
      end else begin
         state       <= state_n;
         frame_cnt   <= frame_cnt_n;
         acc         <= acc_n;
         spawn_valid <= valid_n;
         spawn_x     <= x_n;
         spawn_type  <= type_n;
         spawn_cnt   <= cnt_n;
`ifdef ENEMY_SPAWN_DIFFICULTY_EN
         interval    <= interval_n;
         step_cnt    <= step_cnt_n;
`endif
      end
   end

endmodule
